// File: rtl/mysystem_pll_pkg.sv
// rtl/mysystem_pll_pkg.sv - shared state encoding and widths for the PLL lock supervisor
package mysystem_pll_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

endpackage

// File: rtl/mysystem_bit_sync.sv
// rtl/mysystem_bit_sync.sv - two-flop synchronizer for a single asynchronous status bit
module mysystem_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mysystem_pll_lock_supervisor.sv
// rtl/mysystem_pll_lock_supervisor.sv - sequences PLL reset, qualifies lock and gates downstream reset
module mysystem_pll_lock_supervisor
    import mysystem_pll_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count
);

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic               lk;
    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               fail_evt;
    logic               pll_rst_q, sys_reset_q, ready_q, fail_q;

    mysystem_bit_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lk)
    );

    always_comb begin
        retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;
        state_d   = state_q;
        timer_d   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        retry_d   = retry_q;
        fail_evt  = 1'b0;
        if (relock_req) begin
            state_d = PLL_RST;
            retry_d = '0;
        end else begin
            case (state_q)
                PLL_RST:   if (timer_q >= RST_LAST) state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (lk)                     state_d  = STABLE;
                    else if (timer_q >= TO_LAST) fail_evt = 1'b1;
                end
                // a lock drop on the completing cycle still counts as a failure
                STABLE: begin
                    if (!lk) begin
                        fail_evt = 1'b1;
                    end else if (timer_q >= STB_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN:       if (!lk) fail_evt = 1'b1;
                FAIL:      state_d = FAIL;
                default:   state_d = PLL_RST;
            endcase
            if (fail_evt) begin
                retry_d = retry_inc;
                state_d = (retry_inc >= RETRY_MAX) ? FAIL : PLL_RST;
            end
        end
        if (state_d != state_q || relock_req) timer_d = '0;
    end

    // outputs decode the next state so they change on the same edge as the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PLL_RST;
            timer_q     <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == PLL_RST);
            sys_reset_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
            fail_q      <= (state_d == FAIL);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_mysystem_pll_lock_supervisor.sv
// tb/tb_mysystem_pll_lock_supervisor.sv - self-checking bench for the PLL lock supervisor
module tb_mysystem_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 3;

    logic       clk = 1'b0;
    logic       rst, pll_locked, relock_req;
    logic       pll_rst, sys_reset, ready, fail;
    logic [3:0] retry_count;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mysystem_pll_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count)
    );

    // Reference model: each phase remembers the cycle it began; durations are elapsed cycle counts.
    typedef enum {M_RST, M_WAIT, M_STABLE, M_RUN, M_FAIL} mphase_e;
    mphase_e m_ph;
    int      cyc, m_t0, m_n, m_retries;
    bit      lkq[$];
    bit      m_lk;

    function automatic void enter(mphase_e p);
        m_ph = p;
        m_t0 = cyc;
    endfunction

    function automatic void failure();
        m_retries = (m_retries < 15) ? m_retries + 1 : 15;
        enter((m_retries >= MAX_RETRIES) ? M_FAIL : M_RST);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0;
            m_retries = 0;
            lkq.delete();
            enter(M_RST);
        end else begin
            cyc++;
            lkq.push_back(pll_locked === 1'b1);
            if (lkq.size() > 3) void'(lkq.pop_front());
            m_lk = (lkq.size() >= 3) ? lkq[0] : 1'b0;
            m_n = cyc - m_t0;
            if (relock_req) begin
                m_retries = 0;
                enter(M_RST);
            end else begin
                case (m_ph)
                    M_RST:    if (m_n >= RST_CYCLES) enter(M_WAIT);
                    M_WAIT:   if (m_lk) enter(M_STABLE); else if (m_n >= LOCK_TIMEOUT) failure();
                    M_STABLE: if (!m_lk) failure();
                              else if (m_n >= STABLE_CYCLES) begin m_retries = 0; enter(M_RUN); end
                    M_RUN:    if (!m_lk) failure();
                    default:  ;
                endcase
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_pll_rst_low();
        for (int i = 0; i < 100 && pll_rst === 1'b1; i++) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({pll_rst, sys_reset, ready, fail, retry_count} !== 8'b1100_0000) begin
            errors++;
            $display("FAIL reset_values: got %b required 11000000", {pll_rst, sys_reset, ready, fail, retry_count});
        end
    endtask

    task automatic test_lock_sequence();
        int hi;
        int d;
        do_reset();
        hi = 0;
        while (pll_rst === 1'b1 && hi < 50) begin hi++; tick(); end
        checks++;
        if (hi != RST_CYCLES) begin errors++; $display("FAIL pll_rst_width: got %0d required %0d", hi, RST_CYCLES); end
        d = $urandom_range(1, 12);
        repeat (d) tick();
        pll_locked = 1'b1;
        repeat (10) tick();
        checks++;
        if ({ready, sys_reset} !== 2'b01) begin errors++; $display("FAIL early_ready: got %b required 01", {ready, sys_reset}); end
        tick();
        checks++;
        if ({ready, sys_reset, pll_rst, retry_count} !== 7'b1000000) begin
            errors++;
            $display("FAIL ready_after_lock: got %b required 1000000", {ready, sys_reset, pll_rst, retry_count});
        end
    endtask

    task automatic test_timeout();
        int rises[$];
        int rets[$];
        int fail_t;
        logic prev;
        do_reset();
        fail_t = -1;
        prev = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (t > 0) tick();
            if (pll_rst === 1'b1 && prev !== 1'b1) begin rises.push_back(t); rets.push_back(int'(retry_count)); end
            prev = pll_rst;
            if (fail === 1'b1) begin fail_t = t; break; end
        end
        checks++;
        if (rises.size() != 3) begin errors++; $display("FAIL timeout_pulses: got %0d required 3", rises.size()); end
        if (rises.size() >= 3) begin
            checks++;
            if (rises[1] - rises[0] != 24 || rises[2] - rises[1] != 24) begin
                errors++;
                $display("FAIL timeout_spacing: got %0d,%0d required 24,24", rises[1] - rises[0], rises[2] - rises[1]);
            end
            checks++;
            if (rets[1] != 1 || rets[2] != 2) begin
                errors++;
                $display("FAIL retry_steps: got %0d,%0d required 1,2", rets[1], rets[2]);
            end
        end
        checks++;
        if (fail_t != 72 || retry_count !== 4'd3) begin
            errors++;
            $display("FAIL fail_entry: got t=%0d retry=%0d required t=72 retry=3", fail_t, retry_count);
        end
        repeat (30) tick();
        checks++;
        if ({fail, pll_rst, sys_reset, ready, retry_count} !== 8'b1010_0011) begin
            errors++;
            $display("FAIL fail_terminal: got %b required 10100011", {fail, pll_rst, sys_reset, ready, retry_count});
        end
    endtask

    task automatic test_run_drop();
        int w;
        do_reset();
        wait_pll_rst_low();
        pll_locked = 1'b1;
        repeat (12) tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL run_reached: got %b required 1", ready); end
        pll_locked = 1'b0;
        w = 0;
        while (w < 3) begin w++; tick(); if (sys_reset === 1'b1) break; end
        checks++;
        if ({sys_reset, ready, pll_rst, retry_count} !== 7'b1010001) begin
            errors++;
            $display("FAIL run_drop: got %b after %0d cycles required 1010001", {sys_reset, ready, pll_rst, retry_count}, w);
        end
        repeat (3 - w) tick();
        pll_locked = 1'b1;
        w = 0;
        while (w < 60 && ready !== 1'b1) begin w++; tick(); end
        checks++;
        if ({ready, retry_count} !== 5'b10000) begin
            errors++;
            $display("FAIL relock_run: got %b required 10000", {ready, retry_count});
        end
    endtask

    task automatic test_stable_glitch();
        int fall_t;
        bit rose;
        do_reset();
        wait_pll_rst_low();
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        fall_t = -1;
        rose = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (ready === 1'b1) break;
            if (pll_rst === 1'b1) rose = 1'b1;
            else if (rose) begin fall_t = t; break; end
        end
        checks++;
        if (!rose || fall_t < 0 || ready !== 1'b0 || retry_count !== 4'd1) begin
            errors++;
            $display("FAIL stable_glitch: got rose=%0d ready=%b retry=%0d required rose=1 ready=0 retry=1", rose, ready, retry_count);
        end
        repeat (8) tick();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL stable_restart_early: got %b required 0", ready); end
        tick();
        checks++;
        if ({ready, retry_count} !== 5'b10000) begin
            errors++;
            $display("FAIL stable_restart: got %b required 10000", {ready, retry_count});
        end
    endtask

    task automatic test_relock();
        int hi;
        do_reset();
        for (int i = 0; i < 200 && fail !== 1'b1; i++) tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++;
        if ({fail, retry_count, pll_rst} !== 6'b000001) begin
            errors++;
            $display("FAIL relock_from_fail: got %b required 000001", {fail, retry_count, pll_rst});
        end
        hi = 0;
        while (pll_rst === 1'b1 && hi < 50) begin hi++; tick(); end
        checks++;
        if (hi != RST_CYCLES) begin errors++; $display("FAIL relock_pulse: got %0d required %0d", hi, RST_CYCLES); end
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        hi = 0;
        while (pll_rst === 1'b1 && hi < 50) begin hi++; tick(); end
        checks++;
        if (hi != RST_CYCLES) begin errors++; $display("FAIL relock_restart: got %0d required %0d", hi, RST_CYCLES); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 100 && retry_count !== 4'd1; i++) tick();
        wait_pll_rst_low();
        pll_locked = 1'b1;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pll_rst, sys_reset, ready, fail, retry_count} !== 8'b1100_0000) begin
            errors++;
            $display("FAIL async_reset: got %b required 11000000", {pll_rst, sys_reset, ready, fail, retry_count});
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        int hold;
        logic [7:0] exp_v;
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            hold = 0;
            for (int c = 0; c < 600; c++) begin
                if (hold == 0) begin
                    pll_locked = ($urandom_range(0, 3) != 0);
                    hold = $urandom_range(1, 40);
                end
                hold--;
                relock_req = ($urandom_range(0, 99) == 0);
                tick();
                exp_v = {m_ph == M_RST, m_ph != M_RUN, m_ph == M_RUN, m_ph == M_FAIL, 4'(m_retries)};
                checks++;
                if ({pll_rst, sys_reset, ready, fail, retry_count} !== exp_v) begin
                    errors++;
                    $display("FAIL random ep%0d cyc%0d: got %b required %b", ep, c, {pll_rst, sys_reset, ready, fail, retry_count}, exp_v);
                end
            end
            relock_req = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        test_reset();
        test_lock_sequence();
        test_timeout();
        test_run_drop();
        test_stable_glitch();
        test_relock();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
